// File: rtl/seq_det_pkg.sv
// Shared types and reset defaults for the parametrised serial sequence detector.
package seq_det_pkg;

  typedef enum logic [0:0] {
    StDisarmed,
    StArmed
  } state_e;

  localparam logic [3:0]  PAT_DEFAULT = 4'b1010;
  localparam int unsigned LEN_DEFAULT = 4;
  localparam bit          OVL_DEFAULT = 1'b1;

  // Width needed to hold a pattern length in the range 0..pat_w.
  function automatic int unsigned len_width(input int unsigned pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear and increment together yield 1.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = inc ? W'(1) : '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/seq_detector_param.sv
// Serial detector for a runtime-programmable pattern of 1..PAT_W bits, with overlap
// control, a registered match pulse and a saturating match counter.
module seq_detector_param #(
  parameter int unsigned           PAT_W       = 4,
  parameter int unsigned           CNT_W       = 8,
  parameter logic [PAT_W-1:0]      PAT_DEFAULT = PAT_W'(seq_det_pkg::PAT_DEFAULT),
  parameter int unsigned           LEN_DEFAULT = seq_det_pkg::LEN_DEFAULT,
  parameter bit                    OVL_DEFAULT = seq_det_pkg::OVL_DEFAULT,
  localparam int unsigned          LW          = seq_det_pkg::len_width(PAT_W)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LW-1:0]    cfg_len,
  input  logic             cfg_overlap,
  input  logic             count_clear,
  output logic             out,
  output logic             armed,
  output logic             cfg_err,
  output logic [CNT_W-1:0] match_count
);

  import seq_det_pkg::*;

  state_e           state_d, state_q;
  logic [PAT_W-1:0] pat_d, pat_q;
  logic [LW-1:0]    len_d, len_q;
  logic             ovl_d, ovl_q;
  logic [PAT_W-1:0] hist_d, hist_q;
  logic [LW-1:0]    fill_d, fill_q;
  logic             out_d, out_q;
  logic             err_d, err_q;

  logic             cfg_ok;
  logic             sample;
  logic             match;
  logic [PAT_W-1:0] hist_next;
  logic [LW-1:0]    fill_next;
  logic [PAT_W-1:0] len_mask;

  assign cfg_ok    = (cfg_len != '0) && (cfg_len <= LW'(PAT_W));
  // A bit presented alongside cfg_load is discarded.
  assign sample    = (state_q == StArmed) && in_valid && !cfg_load;
  assign hist_next = {hist_q[PAT_W-2:0], in};
  assign fill_next = (fill_q == LW'(PAT_W)) ? fill_q : fill_q + LW'(1);

  always_comb begin
    len_mask = '0;
    for (int unsigned i = 0; i < PAT_W; i++) begin
      len_mask[i] = (LW'(i) < len_q);
    end
  end

  assign match = sample && (fill_next >= len_q) && (((hist_next ^ pat_q) & len_mask) == '0);

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    err_d   = err_q;
    out_d   = 1'b0;
    if (cfg_load) begin
      if (cfg_ok) begin
        pat_d   = cfg_pattern;
        len_d   = cfg_len;
        ovl_d   = cfg_overlap;
        hist_d  = '0;
        fill_d  = '0;
        state_d = StArmed;
        err_d   = 1'b0;
      end else begin
        state_d = StDisarmed;
        err_d   = 1'b1;
      end
    end else if (sample) begin
      hist_d = hist_next;
      // Non-overlap restarts the fill so matched bits cannot seed the next match.
      fill_d = (match && !ovl_q) ? '0 : fill_next;
      out_d  = match;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StArmed;
      pat_q   <= PAT_DEFAULT;
      len_q   <= LW'(LEN_DEFAULT);
      ovl_q   <= OVL_DEFAULT;
      hist_q  <= '0;
      fill_q  <= '0;
      out_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_sat_counter (
    .clk  (clk),
    .reset(reset),
    .clear(count_clear),
    .inc  (match),
    .count(match_count)
  );

  assign out     = out_q;
  assign armed   = (state_q == StArmed);
  assign cfg_err = err_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param built with PAT_W=8 and CNT_W=2.
module tb_seq_detector_param;

  localparam int unsigned PAT_W = 8;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned LW    = $clog2(PAT_W + 1);

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             din;
  logic             cfg_load;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LW-1:0]    cfg_len;
  logic             cfg_overlap;
  logic             count_clear;
  logic             out;
  logic             armed;
  logic             cfg_err;
  logic [CNT_W-1:0] match_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_detector_param #(
    .PAT_W      (PAT_W),
    .CNT_W      (CNT_W),
    .PAT_DEFAULT(8'b0000_1010),
    .LEN_DEFAULT(4),
    .OVL_DEFAULT(1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in         (din),
    .cfg_load   (cfg_load),
    .cfg_pattern(cfg_pattern),
    .cfg_len    (cfg_len),
    .cfg_overlap(cfg_overlap),
    .count_clear(count_clear),
    .out        (out),
    .armed      (armed),
    .cfg_err    (cfg_err),
    .match_count(match_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bit_in(input logic b, input logic exp_out, input string tag);
    in_valid = 1'b1;
    din      = b;
    tick();
    in_valid = 1'b0;
    chk(tag, {31'd0, out}, {31'd0, exp_out});
  endtask

  task automatic load(input logic [PAT_W-1:0] pat, input logic [LW-1:0] len, input logic ovl);
    cfg_load    = 1'b1;
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ovl;
    tick();
    cfg_load = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    in_valid    = 1'b0;
    din         = 1'b0;
    cfg_load    = 1'b0;
    cfg_pattern = '0;
    cfg_len     = '0;
    cfg_overlap = 1'b0;
    count_clear = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_out", {31'd0, out}, 32'd0);
    chk("rst_armed", {31'd0, armed}, 32'd1);
    chk("rst_err", {31'd0, cfg_err}, 32'd0);
    chk("rst_count", {30'd0, match_count}, 32'd0);

    // Reset defaults 1010, overlapping.
    bit_in(1'b1, 1'b0, "ovl_b1");
    bit_in(1'b0, 1'b0, "ovl_b2");
    bit_in(1'b1, 1'b0, "ovl_b3");
    bit_in(1'b0, 1'b1, "ovl_b4");
    bit_in(1'b1, 1'b0, "ovl_b5");
    bit_in(1'b0, 1'b1, "ovl_b6");
    chk("ovl_count", {30'd0, match_count}, 32'd2);

    count_clear = 1'b1;
    tick();
    count_clear = 1'b0;
    chk("clr_count", {30'd0, match_count}, 32'd0);

    // Non-overlap; a bit offered with cfg_load must be dropped.
    in_valid = 1'b1;
    din      = 1'b1;
    load(8'b0000_1010, LW'(4), 1'b0);
    in_valid = 1'b0;
    chk("load_out", {31'd0, out}, 32'd0);
    bit_in(1'b1, 1'b0, "novl_b1");
    bit_in(1'b0, 1'b0, "novl_b2");
    bit_in(1'b1, 1'b0, "novl_b3");
    bit_in(1'b0, 1'b1, "novl_b4");
    bit_in(1'b1, 1'b0, "novl_b5");
    bit_in(1'b0, 1'b0, "novl_b6");
    bit_in(1'b1, 1'b0, "novl_b7");
    bit_in(1'b0, 1'b1, "novl_b8");
    chk("novl_count", {30'd0, match_count}, 32'd2);

    // Illegal lengths disarm and set the sticky error.
    load(8'b0000_1010, LW'(0), 1'b1);
    chk("len0_err", {31'd0, cfg_err}, 32'd1);
    chk("len0_armed", {31'd0, armed}, 32'd0);
    bit_in(1'b1, 1'b0, "dis_b1");
    bit_in(1'b0, 1'b0, "dis_b2");
    bit_in(1'b1, 1'b0, "dis_b3");
    bit_in(1'b0, 1'b0, "dis_b4");
    chk("dis_count", {30'd0, match_count}, 32'd2);
    load(8'b0000_1010, LW'(9), 1'b1);
    chk("len9_err", {31'd0, cfg_err}, 32'd1);
    chk("len9_armed", {31'd0, armed}, 32'd0);
    load(8'b0000_0110, LW'(3), 1'b1);
    chk("len3_err", {31'd0, cfg_err}, 32'd0);
    chk("len3_armed", {31'd0, armed}, 32'd1);
    bit_in(1'b1, 1'b0, "l3_b1");
    bit_in(1'b1, 1'b0, "l3_b2");
    bit_in(1'b0, 1'b1, "l3_b3");
    chk("l3_count", {30'd0, match_count}, 32'd3);

    // len=1, non-overlap, counter saturates at 3.
    count_clear = 1'b1;
    load(8'b0000_0001, LW'(1), 1'b0);
    count_clear = 1'b0;
    chk("l1_clr", {30'd0, match_count}, 32'd0);
    bit_in(1'b1, 1'b1, "l1_b1");
    chk("l1_c1", {30'd0, match_count}, 32'd1);
    bit_in(1'b1, 1'b1, "l1_b2");
    chk("l1_c2", {30'd0, match_count}, 32'd2);
    bit_in(1'b1, 1'b1, "l1_b3");
    chk("l1_c3", {30'd0, match_count}, 32'd3);
    bit_in(1'b1, 1'b1, "l1_b4");
    chk("l1_c4", {30'd0, match_count}, 32'd3);
    bit_in(1'b1, 1'b1, "l1_b5");
    chk("l1_c5", {30'd0, match_count}, 32'd3);
    bit_in(1'b0, 1'b0, "l1_b6");
    count_clear = 1'b1;
    bit_in(1'b1, 1'b1, "l1_clrhit");
    count_clear = 1'b0;
    chk("clrhit_count", {30'd0, match_count}, 32'd1);
    count_clear = 1'b1;
    tick();
    count_clear = 1'b0;
    chk("clr_alone", {30'd0, match_count}, 32'd0);
    chk("clr_alone_out", {31'd0, out}, 32'd0);

    // Reset mid-stream discards the partial prefix.
    load(8'b0000_1010, LW'(4), 1'b1);
    bit_in(1'b1, 1'b0, "rs_b1");
    bit_in(1'b0, 1'b0, "rs_b2");
    bit_in(1'b1, 1'b0, "rs_b3");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rs_armed", {31'd0, armed}, 32'd1);
    bit_in(1'b0, 1'b0, "rs_b4");
    // Gaps in in_valid do not break the prefix.
    bit_in(1'b1, 1'b0, "gap_b1");
    bit_in(1'b0, 1'b0, "gap_b2");
    bit_in(1'b1, 1'b0, "gap_b3");
    tick();
    chk("gap_idle1", {31'd0, out}, 32'd0);
    tick();
    tick();
    chk("gap_idle3", {31'd0, out}, 32'd0);
    bit_in(1'b0, 1'b1, "gap_b4");
    tick();
    chk("gap_drop", {31'd0, out}, 32'd0);
    chk("gap_count", {30'd0, match_count}, 32'd1);

    // Full-width pattern with overlap: stream 11011011011 matches after bits 8 and 11.
    load(8'b1101_1011, LW'(8), 1'b1);
    bit_in(1'b1, 1'b0, "w8_b1");
    bit_in(1'b1, 1'b0, "w8_b2");
    bit_in(1'b0, 1'b0, "w8_b3");
    bit_in(1'b1, 1'b0, "w8_b4");
    bit_in(1'b1, 1'b0, "w8_b5");
    bit_in(1'b0, 1'b0, "w8_b6");
    bit_in(1'b1, 1'b0, "w8_b7");
    bit_in(1'b1, 1'b1, "w8_b8");
    bit_in(1'b0, 1'b0, "w8_b9");
    bit_in(1'b1, 1'b0, "w8_b10");
    bit_in(1'b1, 1'b1, "w8_b11");
    chk("w8_count", {30'd0, match_count}, 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
